// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine coin sequencer: core coin codes,
// price in half-yuan units and the sequencer FSM state type.
package vm_pkg;

    localparam logic [1:0] VM_NONE = 2'b00;
    localparam logic [1:0] VM_HALF = 2'b01;
    localparam logic [1:0] VM_ONE  = 2'b10;

    localparam logic [2:0] PRICE_HALVES = 3'd3;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StGap,
        StRefund
    } vm_state_e;

    // Slot value bit (0 = 0.5 yuan, 1 = 1 yuan) to core D_in code.
    function automatic logic [1:0] coin_code(input logic val);
        return val ? VM_ONE : VM_HALF;
    endfunction

    function automatic logic [2:0] coin_halves(input logic [1:0] code);
        return (code == VM_ONE) ? 3'd2 : ((code == VM_HALF) ? 3'd1 : 3'd0);
    endfunction

endpackage

// File: rtl/vm_coin_sequencer_if.sv
// Coin-slot handshakes plus the link to the vending-machine core.
// master = coin acceptors and core side, slave = the sequencer.
interface vm_coin_sequencer_if;

    logic       coin_a_valid;
    logic       coin_a_val;
    logic       coin_a_ready;
    logic       coin_b_valid;
    logic       coin_b_val;
    logic       coin_b_ready;
    logic [1:0] vm_d_in;
    logic       vm_clr;
    logic       vm_d_out;
    logic       vm_d_c;

    modport master (
        output coin_a_valid, coin_a_val, coin_b_valid, coin_b_val, vm_d_out, vm_d_c,
        input  coin_a_ready, coin_b_ready, vm_d_in, vm_clr
    );

    modport slave (
        input  coin_a_valid, coin_a_val, coin_b_valid, coin_b_val, vm_d_out, vm_d_c,
        output coin_a_ready, coin_b_ready, vm_d_in, vm_clr
    );

endinterface

// File: rtl/vm_coin_fifo.sv
// 1-bit wide coin queue; the extra pointer MSB separates full from empty.
module vm_coin_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [DEPTH-1:0] mem_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= push_data;
                wptr_q                <= wptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vm_coin_sequencer.sv
// Front end for the vending-machine core: arbitrates two coin slots, paces coins into
// the core, mirrors its credit to check dispense/change and refunds stranded credit.
module vm_coin_sequencer
    import vm_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CW      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    vm_coin_sequencer_if.slave  bus,
    output logic [CW-1:0]       sale_cnt,
    output logic [CW-1:0]       change_cnt,
    output logic                refund_pulse,
    output logic [1:0]          refund_amt,
    output logic                err,
    output logic                busy
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    vm_state_e     state_q;
    logic [2:0]    credit_q;
    logic [GW-1:0] gap_cnt_q;
    logic [TW-1:0] timer_q;
    logic          rr_q;
    logic [1:0]    vm_d_in_q;
    logic          vm_clr_q;
    logic [CW-1:0] sale_cnt_q;
    logic [CW-1:0] change_cnt_q;
    logic          refund_pulse_q;
    logic [1:0]    refund_amt_q;
    logic          err_q;

    logic grant_a, grant_b, push, push_data, pop, pop_data, full, empty;
    logic timer_run, timer_expire, exp_out, exp_c;

    // rr_q = 0 favours slot A when both slots offer a coin.
    always_comb begin
        grant_a      = bus.coin_a_valid && (!bus.coin_b_valid || !rr_q);
        grant_b      = bus.coin_b_valid && (!bus.coin_a_valid || rr_q);
        timer_run    = (state_q == StIdle) && (credit_q != 3'd0) && empty;
        timer_expire = timer_run && (timer_q == TW'(TIMEOUT - 1));
        exp_out      = (credit_q >= PRICE_HALVES);
        exp_c        = (credit_q == (PRICE_HALVES + 3'd1));
    end

    assign bus.coin_a_ready = grant_a && !full;
    assign bus.coin_b_ready = grant_b && !full;
    assign push             = bus.coin_a_ready || bus.coin_b_ready;
    assign push_data        = bus.coin_a_ready ? bus.coin_a_val : bus.coin_b_val;
    assign pop              = (state_q == StIdle) && !empty && !timer_expire;

    vm_coin_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            credit_q       <= 3'd0;
            gap_cnt_q      <= '0;
            timer_q        <= '0;
            rr_q           <= 1'b0;
            vm_d_in_q      <= VM_NONE;
            vm_clr_q       <= 1'b1;
            sale_cnt_q     <= '0;
            change_cnt_q   <= '0;
            refund_pulse_q <= 1'b0;
            refund_amt_q   <= 2'd0;
            err_q          <= 1'b0;
        end else begin
            vm_clr_q       <= 1'b0;
            refund_pulse_q <= 1'b0;
            refund_amt_q   <= 2'd0;
            vm_d_in_q      <= VM_NONE;
            if (push) begin
                rr_q <= ~rr_q;
            end
            timer_q <= timer_run ? timer_q + TW'(1) : '0;

            unique case (state_q)
                StIdle: begin
                    if (timer_expire) begin
                        state_q        <= StRefund;
                        vm_clr_q       <= 1'b1;
                        refund_pulse_q <= 1'b1;
                        refund_amt_q   <= credit_q[1:0];
                    end else if (pop) begin
                        vm_d_in_q <= coin_code(pop_data);
                        state_q   <= StDrive;
                    end
                end
                StDrive: begin
                    credit_q  <= credit_q + coin_halves(vm_d_in_q);
                    gap_cnt_q <= '0;
                    state_q   <= StGap;
                end
                StGap: begin
                    // The core answers the coin one cycle after seeing it.
                    if (gap_cnt_q == '0) begin
                        if ((bus.vm_d_out != exp_out) || (bus.vm_d_c != exp_c)) begin
                            err_q <= 1'b1;
                        end
                        if (exp_out) begin
                            credit_q <= 3'd0;
                            if (sale_cnt_q != {CW{1'b1}}) begin
                                sale_cnt_q <= sale_cnt_q + CW'(1);
                            end
                            if (exp_c && (change_cnt_q != {CW{1'b1}})) begin
                                change_cnt_q <= change_cnt_q + CW'(1);
                            end
                        end
                    end
                    if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                StRefund: begin
                    credit_q <= 3'd0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.vm_d_in  = vm_d_in_q;
    assign bus.vm_clr   = vm_clr_q;
    assign sale_cnt     = sale_cnt_q;
    assign change_cnt   = change_cnt_q;
    assign refund_pulse = refund_pulse_q;
    assign refund_amt   = refund_amt_q;
    assign err          = err_q;
    assign busy         = !empty || (state_q != StIdle);

endmodule

// File: doc/vm_coin_sequencer.md
Name: vm_coin_sequencer

Overview:
Front-end controller for the vending-machine core, which has a price of 1.5 yuan, 0.5/1 yuan coin codes on D_in[1:0], and a dispense (D_out) and change (D_C) output.
- Arbitrates two coin acceptors and queues their coins in a small FIFO.
- Feeds the core one coin at a time with a mandatory idle gap.
- Keeps a credit mirror and checks the core's dispense/change outputs against it.
- Refunds stranded credit after a timeout by clearing the core.

Parameters:
DEPTH, 4, coin FIFO entries (power of two, >=2)
GAP_CYC, 2, idle cycles (D_in=00) after each issued coin, >=1
TIMEOUT, 1000, idle cycles with nonzero credit before a refund
CW, 8, width of the sale and change counters

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
coin_a_valid  in  1  slot A has a coin
coin_a_val  in  1  slot A coin value: 0=0.5 yuan, 1=1 yuan
coin_a_ready  out  1  slot A coin accepted this cycle
coin_b_valid  in  1  slot B has a coin
coin_b_val  in  1  slot B coin value, same encoding
coin_b_ready  out  1  slot B coin accepted this cycle
vm_d_in  out  2  to core D_in: 00 none, 01 = 0.5 yuan, 10 = 1 yuan
vm_clr  out  1  active-high clear to the core
vm_d_out  in  1  core dispense output
vm_d_c  in  1  core change output
sale_cnt  out  CW  drinks dispensed, saturating
change_cnt  out  CW  change coins returned, saturating
refund_pulse  out  1  one-cycle refund strobe
refund_amt  out  2  credit refunded in half-yuan units (1 or 2), valid with refund_pulse
err  out  1  sticky: core output disagrees with the credit mirror
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values:
  - vm_clr=1, so the core is held clear during reset; it deasserts on the first clock edge after release.
  - All other outputs are 0; credit=0; FIFO empty; state=IDLE; round-robin pointer favours A.
- Acceptance (valid/ready):
  - A coin transfers when valid && ready. ready is combinational: FIFO not full && granted.
  - At most one coin is accepted per cycle.
  - If both slots are valid, round-robin grants one; the pointer toggles only on a granted transfer.
  - If the FIFO is full, both ready signals are 0.
  - A push and a pop in the same cycle are legal when full.
- FSM states: IDLE, DRIVE, GAP, REFUND.
  - IDLE -> DRIVE when the FIFO is non-empty: pop the FIFO; next cycle vm_d_in = coin code.
  - DRIVE lasts 1 cycle. Update credit in half units: +1 for 0.5, +2 for 1. Then go to GAP.
  - GAP holds vm_d_in=00 for GAP_CYC cycles.
    - In the first GAP cycle, sample vm_d_out/vm_d_c.
    - Expected response: credit>=3 -> d_out=1, and d_c=(credit==4); otherwise both 0.
    - Any mismatch sets err (cleared only by Reset).
    - On credit>=3: credit<=0; sale_cnt+1; change_cnt+1 if credit==4.
  - GAP -> IDLE after GAP_CYC cycles.
  - Idle timer:
    - Counts in IDLE while credit!=0 and the FIFO is empty.
    - Clears on any pop or whenever credit==0.
    - At TIMEOUT, go to REFUND.
  - REFUND lasts 1 cycle:
    - vm_clr=1, refund_pulse=1, refund_amt=credit.
    - credit<=0; return to IDLE.
    - If the FIFO became non-empty in the same cycle the timer expired, refund still takes priority and the coin waits.
- All outputs to the core are registered. vm_d_in is never nonzero in two consecutive cycles.
- Counters saturate at 2^CW-1 with no wrap.
- FIFO pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.
- Reset asserted mid-operation:
  - Immediately: FIFO flushed, credit lost, vm_clr=1.
  - No refund_pulse is generated for credit lost on reset.

Decomposition:
- Shared package vm_pkg holds:
  - coin code constants (VM_NONE=2'b00, VM_HALF=2'b01, VM_ONE=2'b10);
  - PRICE_HALVES=3;
  - the FSM state enum.
- One sub-module, vm_coin_fifo:
  - width 1, depth DEPTH;
  - push/pop/full/empty;
  - same clock/reset.
- Arbiter, credit mirror and FSM live in the top.

Test Plan:
- Reset, then three 0.5 coins on slot A:
  - vm_d_in shows 01 three times, separated by at least GAP_CYC zeros.
  - Drive vm_d_out=1 in the GAP cycle after the third coin -> sale_cnt=1, change_cnt=0, err=0.
- Slots A(1 yuan) and B(1 yuan) valid in the same cycle:
  - A accepted first, B next cycle.
  - Core answers d_out=1, d_c=1 after the second coin -> sale_cnt=1, change_cnt=1.
- Hold coin_a_valid for DEPTH+3 cycles while the core is slow (GAP_CYC=4):
  - coin_a_ready drops when 4 entries are queued.
  - All coins are eventually issued in order with none lost.
- One 1-yuan coin, then silence, with TIMEOUT=20:
  - refund_pulse appears exactly 20 idle cycles after returning to IDLE, with refund_amt=2.
  - vm_clr is high for that cycle and credit returns to 0.
- After 0.5+1 coins, the core responds d_out=0 in the GAP cycle -> err=1, and err stays 1 until Reset.
- Assert Reset while the FIFO holds 3 coins and credit=1:
  - Outputs return to reset values, vm_clr=1, busy=0.
  - No refund_pulse.
